alu_exec_stage: RTL
===================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream presents a, b, op, set_flags.
REQ-005 in_ready  output  1  stage can accept this cycle.
REQ-006 op  input  3  opcode: 000 ADD a+b, 001 SUB a-b, 010 RSB b-a, 011 AND, 100 ORR, 101 EOR, 110 MOV b, 111 MVN ~b.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 set_flags  input  1  S-suffix; update flag register on accept.
REQ-010 out_valid  output  1  result register holds an undelivered result.
REQ-011 out_ready  input  1  downstream consumes result this cycle.
REQ-012 result  output  WIDTH  registered operation result.
REQ-013 flags  output  4  registered NZCV, bit3 N, bit2 Z, bit1 C, bit0 V.

Function
REQ-014 Accept occurs on a rising edge with in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-015 in_ready SHALL equal !out_valid || out_ready (combinational; accept and transfer in the same cycle allowed).
REQ-016 Latency SHALL be 1 cycle: result and flags reflect an accepted op on the edge of acceptance.
REQ-017 out_valid SHALL set on accept, clear on transfer without simultaneous accept, stay 1 on simultaneous transfer+accept.
REQ-018 result and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-019 Arithmetic SHALL be modulo 2^WIDTH; SUB computed as a + ~b + 1, RSB as b + ~a + 1.
REQ-020 C: ADD = carry out; SUB = 1 iff a >= b unsigned; RSB = 1 iff b >= a unsigned.
REQ-021 V: signed overflow of the ADD/SUB/RSB operation as defined by REQ-019.
REQ-022 N = result[WIDTH-1]; Z = 1 iff result == 0.
REQ-023 Logical/move ops (011-111) with set_flags SHALL update N and Z only; C and V retain prior values.
REQ-024 flags SHALL update only on accept with set_flags=1; otherwise hold, independent of out_ready.
REQ-025 Inputs while in_ready=0 SHALL be ignored; no op is dropped or duplicated.

Reset
REQ-026 While rst=1 at a rising edge: out_valid=0, result=0, flags=4'b0000; in_ready=1 after the edge.
REQ-027 rst SHALL take priority over a simultaneous accept or transfer; a pending result is discarded.
REQ-028 After rst deasserts, the first accept SHALL behave as in REQ-016 with no extra cycle.

Structure
REQ-029 Shared package alu_pkg SHALL hold opcode constants, NZCV bit index constants and the default WIDTH.
REQ-030 One combinational sub-module alu_core (a, b, op -> result, n, z, c, v) SHALL contain the datapath; alu_exec_stage holds the handshake and registers.
REQ-031 No state beyond out_valid, result register and flag register.

Verification
REQ-032 RSB, a=00000005, b=00000003, set_flags=1 -> result FFFFFFFE, flags 1000 next cycle.
REQ-033 RSB, a=7FFFFFFF, b=80000001, set_flags=1 -> result 00000002, flags 0011.
REQ-034 ADD, a=FFFFFFFF, b=00000001, set_flags=1 then AND a=0, b=0, set_flags=1 -> 00000000/0110, then 00000000/0110 (C held).
REQ-035 out_ready=0, two back-to-back SUB ops (9-4, 1-2) -> in_ready=0 after first; result 00000005 holds; after out_ready=1, 00000005 then FFFFFFFF, none lost.
REQ-036 Accept SUB with set_flags=1, assert rst next cycle with out_ready=0 -> out_valid=0, result 0, flags 0000.
REQ-037 Streaming, out_ready=1 continuously, 8 mixed ops with set_flags=0 -> one result per cycle, flags unchanged from reset.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, NZCV bit positions, default width.
// Imported by the exec stage, its interface and the datapath core.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_RSB = 3'b010,
    OP_AND = 3'b011,
    OP_ORR = 3'b100,
    OP_EOR = 3'b101,
    OP_MOV = 3'b110,
    OP_MVN = 3'b111
  } alu_op_e;

  // Only add/sub family produces meaningful C and V.
  function automatic logic is_arith(
    input logic [2:0] op
  );
    return (op == OP_ADD) ||
           (op == OP_SUB) ||
           (op == OP_RSB);
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Handshake bundle of the ALU execute stage: upstream operands
// with valid/ready, downstream result/flags with valid/ready.
interface alu_exec_stage_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             set_flags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid,
    output op,
    output a,
    output b,
    output set_flags,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  flags
  );

  modport slave (
    input  in_valid,
    input  op,
    input  a,
    input  b,
    input  set_flags,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output flags
  );

endinterface

// File: rtl/alu_exec_stage_core.sv
// Combinational ALU datapath: one shared adder serves ADD/SUB/RSB,
// logic and move ops bypass it. Produces raw N, Z, C, V.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             n_o,
  output logic             z_o,
  output logic             c_o,
  output logic             v_o
);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;

  // Subtraction folds into the adder as x + ~y + 1.
  always_comb begin
    x   = a_i;
    y   = b_i;
    cin = 1'b0;
    unique case (1'b1)
      (op_i == OP_SUB): begin
        y   = ~b_i;
        cin = 1'b1;
      end
      (op_i == OP_RSB): begin
        x   = b_i;
        y   = ~a_i;
        cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum = {1'b0, x}
             + {1'b0, y}
             + {{WIDTH{1'b0}}, cin};

  always_comb begin
    res = sum[WIDTH-1:0];
    unique case (1'b1)
      (op_i == OP_AND): res = a_i & b_i;
      (op_i == OP_ORR): res = a_i | b_i;
      (op_i == OP_EOR): res = a_i ^ b_i;
      (op_i == OP_MOV): res = b_i;
      (op_i == OP_MVN): res = ~b_i;
      default: ;
    endcase
  end

  assign result_o = res;
  assign n_o = res[WIDTH-1];
  assign z_o = (res == '0);
  assign c_o = sum[WIDTH];
  assign v_o = (x[WIDTH-1] == y[WIDTH-1]) &&
               (sum[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: one-deep result register behind a valid/ready
// handshake, plus the NZCV flag register.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input logic               clk,
  input logic               rst,
  alu_exec_stage_if.slave   bus
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic [3:0]       flags_q;
  logic [3:0]       flags_d;

  logic [WIDTH-1:0] core_res;
  logic             core_n;
  logic             core_z;
  logic             core_c;
  logic             core_v;
  logic             in_ready;
  logic             accept;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i      (bus.a),
    .b_i      (bus.b),
    .op_i     (bus.op),
    .result_o (core_res),
    .n_o      (core_n),
    .z_o      (core_z),
    .c_o      (core_c),
    .v_o      (core_v)
  );

  assign in_ready = !valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (accept) begin
      valid_d  = 1'b1;
      result_d = core_res;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
    // Logic ops keep the last arithmetic C and V.
    if (accept && bus.set_flags) begin
      flags_d[FLAG_N] = core_n;
      flags_d[FLAG_Z] = core_z;
      if (is_arith(bus.op)) begin
        flags_d[FLAG_C] = core_c;
        flags_d[FLAG_V] = core_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= 4'b0000;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule
